// File: rtl/fp_sqrt.sv
// fp_sqrt: multi-cycle truncating IEEE-754 square root on an unpacked operand,
// one restoring digit-by-digit root bit per CALC cycle.
module fp_sqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic [52:0] in_mantisa,
  input  logic [10:0] in_exp,
  input  logic        in_sign,
  input  logic        in_type,
  input  logic [2:0]  in_flags,
  input  logic        start,
  output logic [52:0] out_mantisa,
  output logic [10:0] out_exp,
  output logic        out_sign,
  output logic        ready
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [105:0] rad;
  logic [53:0] rem;
  logic [52:0] root;
  logic [10:0] norm_exp;
  logic typ, sgn;
  logic [2:0] flg;
  logic fire, last, ge, is_nan, is_inf, is_zero;
  logic signed [11:0] e;
  logic [11:0] bias, half_exp;
  logic [55:0] rem_sh, trial;
  logic [10:0] ones;
  logic [52:0] norm_m;
  assign fire = start && state != CALC;
  assign last = state == CALC && cnt == 6'd53;
  always_comb begin
    state_nx = state;
    if (fire) state_nx = CALC;
    else if (last) state_nx = DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  assign bias = in_type ? 12'd1023 : 12'd127;
  assign e = $signed({1'b0, in_type ? in_exp : {3'b0, in_exp[7:0]}} - bias);
  assign half_exp = 12'(e >>> 1) + bias;
  assign rem_sh = {rem, rad[105:104]};
  assign trial = {1'b0, root, 2'b01};
  assign ge = rem_sh >= trial;
  // class priority: NaN pattern, then infinity, then zero, then normal
  assign is_nan = flg == 3'b000 || (flg[0] ? sgn : (!flg[1] && sgn));
  assign is_inf = flg[0] && !sgn;
  assign is_zero = !flg[0] && flg[1];
  assign ones = typ ? 11'h7FF : 11'h0FF;
  assign norm_m = typ ? root : {root[52:29], 29'b0};
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_mantisa <= '0;
      out_exp <= '0;
      out_sign <= 1'b0;
      ready <= 1'b0;
      cnt <= '0;
    end else if (fire) begin
      ready <= 1'b0;
      cnt <= '0;
      rem <= '0;
      root <= '0;
      rad <= e[0] ? {in_mantisa, 53'b0} : {1'b0, in_mantisa, 52'b0};
      typ <= in_type;
      sgn <= in_sign;
      flg <= in_flags;
      norm_exp <= in_type ? half_exp[10:0] : {3'b0, half_exp[7:0]};
    end else if (state == CALC) begin
      if (cnt != 6'd53) begin
        rem <= ge ? 54'(rem_sh - trial) : rem_sh[53:0];
        root <= {root[51:0], ge};
        rad <= rad << 2;
        cnt <= cnt + 6'd1;
      end else begin
        out_mantisa <= is_nan ? 53'h18000000000000 : (is_inf || is_zero) ? 53'd0 : norm_m;
        out_exp <= (is_nan || is_inf) ? ones : is_zero ? 11'd0 : norm_exp;
        out_sign <= is_zero && sgn;
        ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fp_sqrt.sv
// tb_fp_sqrt: scoreboard bench; stimulus pushes expected results, a monitor
// pops and compares on each rising ready, including exact latency.
module tb_fp_sqrt;
  logic clk = 0, rst = 0, start = 0, in_sign = 0, in_type = 1;
  logic [52:0] in_mantisa = '0;
  logic [10:0] in_exp = '0;
  logic [2:0] in_flags = '0;
  logic [52:0] out_mantisa;
  logic [10:0] out_exp;
  logic out_sign, ready;

  fp_sqrt dut (
    .clk(clk), .rst(rst), .in_mantisa(in_mantisa), .in_exp(in_exp),
    .in_sign(in_sign), .in_type(in_type), .in_flags(in_flags), .start(start),
    .out_mantisa(out_mantisa), .out_exp(out_exp), .out_sign(out_sign), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [52:0] m;
    logic [10:0] e;
    logic s;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t x;
  int cyc = 0, checks = 0, failures = 0, got = 0;
  logic prev_ready = 0;
  logic [64:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready === 1'b1 && prev_ready !== 1'b1) begin
      got++;
      if (q.size() == 0) chk("unexpected_ready", 72'd1, 72'd0);
      else begin
        x = q.pop_front();
        chk("mantisa", 72'(out_mantisa), 72'(x.m));
        chk("exp", 72'(out_exp), 72'(x.e));
        chk("sign", 72'(out_sign), 72'(x.s));
        chk("latency", 72'(cyc), 72'(x.cyc));
      end
    end else if (rst) chk("stable", 72'({out_mantisa, out_exp, out_sign}), 72'(last_out));
    last_out = {out_mantisa, out_exp, out_sign};
    prev_ready = ready;
  end

  function automatic logic [52:0] isqrt(input logic [105:0] r);
    logic [52:0] v = '0;
    for (int b = 52; b >= 0; b--) begin
      logic [52:0] c;
      c = v | (53'd1 << b);
      if (106'(c) * 106'(c) <= r) v = c;
    end
    return v;
  endfunction

  task automatic run(input logic [52:0] m, input logic [10:0] ex, input logic s, input logic t,
                     input logic [2:0] f, input logic [52:0] em, input logic [10:0] ee,
                     input logic es, input int hold);
    int n0;
    exp_t item;
    n0 = got;
    @(negedge clk);
    in_mantisa = m; in_exp = ex; in_sign = s; in_type = t; in_flags = f; start = 1;
    item.m = em; item.e = ee; item.s = es; item.cyc = cyc + 55;
    q.push_back(item);
    repeat (hold) @(negedge clk);
    start = 0;
    for (int i = 0; i < 80; i++) begin
      if (got > n0) break;
      @(negedge clk);
    end
    if (got == n0) chk("timeout", 72'd0, 72'd1);
  endtask

  localparam logic [52:0] ONE = 53'd1 << 52;
  localparam logic [52:0] QNAN = 53'h18000000000000;

  initial begin
    logic [52:0] m;
    logic [10:0] ex;
    int e;
    logic [105:0] r;
    rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 72'(ready), 72'd0);
    chk("reset_out", 72'({out_mantisa, out_exp, out_sign}), 72'd0);
    rst = 1;
    run(ONE, 11'd1023, 0, 1, 3'b100, ONE, 11'd1023, 0, 2);
    run(ONE, 11'd1024, 0, 1, 3'b100, 53'h16A09E667F3BCC, 11'd1023, 0, 1);
    run(ONE, 11'd1025, 0, 1, 3'b100, ONE, 11'd1024, 0, 1);
    run(ONE, 11'd5, 0, 1, 3'b100, ONE, 11'd514, 0, 1);
    run(ONE, 11'd700, 1, 1, 3'b010, 53'd0, 11'd0, 1, 1);
    run(ONE, 11'd2047, 0, 1, 3'b001, 53'd0, 11'h7FF, 0, 1);
    run(ONE, 11'd1023, 1, 1, 3'b100, QNAN, 11'h7FF, 0, 1);
    run(ONE, 11'd2047, 0, 1, 3'b000, QNAN, 11'h7FF, 0, 1);
    run(ONE, 11'd2047, 1, 1, 3'b001, QNAN, 11'h7FF, 0, 1);
    run(ONE, 11'd129, 0, 0, 3'b100, ONE, 11'd128, 0, 1);
    run(ONE, 11'd128, 0, 0, 3'b100, 53'h16A09E60000000, 11'd127, 0, 1);
    run(ONE, 11'd255, 0, 0, 3'b001, 53'd0, 11'h0FF, 0, 1);
    run(ONE, 11'd1023, 0, 1, 3'b111, 53'd0, 11'h7FF, 0, 1);
    run(ONE, 11'd1023, 1, 1, 3'b110, 53'd0, 11'd0, 1, 1);
    for (int k = 0; k < 32; k++) begin
      m = {1'b1, 20'($urandom), 32'($urandom)};
      ex = 11'($urandom_range(0, 10));
      e = int'(ex) - 1023;
      r = (e & 1) != 0 ? {m, 53'b0} : {1'b0, m, 52'b0};
      run(m, ex, 0, 1, 3'b100, isqrt(r), 11'((e - (e & 1)) / 2 + 1023), 0, 1);
      if (k == 10) begin
        @(negedge clk);
        in_mantisa = m; in_exp = 11'd1024; in_flags = 3'b100; start = 1;
        @(negedge clk);
        start = 0;
        repeat (19) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("abort_ready", 72'(ready), 72'd0);
        chk("abort_out", 72'({out_mantisa, out_exp, out_sign}), 72'd0);
        repeat (60) @(negedge clk);
        chk("abort_no_result", 72'(ready), 72'd0);
        run(ONE, 11'd1024, 0, 1, 3'b100, 53'h16A09E667F3BCC, 11'd1023, 0, 1);
      end
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", 72'(q.size()), 72'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_sqrt.md
# fp_sqrt

Multi-cycle IEEE-754 square-root unit for the FPU datapath. It takes an already-unpacked operand and returns the unpacked root after a fixed iterative latency:
- operand: 53-bit significand with explicit hidden bit, biased exponent, sign, format type and class flags;
- result: significand, exponent and sign.

Results are truncated; there is no rounding stage.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous active-low reset (asserted when rst=0)
- in_mantisa  in  53  significand, hidden bit at [52]; single format uses [52:29], with [28:0]=0
- in_exp  in  11  biased exponent; bias 1023 for double, 127 for single (single uses [7:0])
- in_sign  in  1  operand sign
- in_type  in  1  1=double, 0=single
- in_flags  in  3  operand class:
  - [2] normal finite nonzero
  - [1] zero
  - [0] infinity
  - all zero = NaN
- start  in  1  request; sampled only in IDLE
- out_mantisa  out  53  result significand, hidden bit at [52]
- out_exp  out  11  result biased exponent
- out_sign  out  1  result sign
- ready  out  1  result valid; high from completion until next accepted start

## Operation
- States: IDLE, CALC, DONE.
  - IDLE: start=1 latches all inputs, clears ready, enters CALC.
  - DONE: behaves as IDLE (accepts start); it differs only in having ready=1.
- start held high across several cycles is accepted once; start is ignored while in CALC.
- Normal operand, positive, unbiased exponent e = in_exp − B (B=1023 or 127), computed in 12-bit signed:
  - Radicand (106 bits): e even → in_mantisa<<52; e odd → in_mantisa<<53.
  - Restoring digit-by-digit integer square root, one result bit per CALC cycle, 53 iterations, MSB first.
  - The 53-bit root always has bit 52 set. The remainder is discarded (truncation).
  - out_exp = (e >>> 1) + B (arithmetic floor shift); out_sign=0.
  - Single: out_mantisa[28:0] forced 0; out_exp[10:8]=0.
- Special cases (still take the full latency):
  - zero → out_mantisa=0, out_exp=0, out_sign=in_sign (so √−0 = −0).
  - +infinity → out_mantisa=0, out_exp=all ones (0x7FF double / 0x0FF single), sign 0.
  - NaN, −infinity, or negative normal → quiet NaN: exp all ones, out_mantisa=53'h18000000000000 (bits 52 and 51 set), sign 0.
- Multiple flag bits set: priority NaN-class check first, then infinity [0], then zero [1], then normal [2].

## Timing
- Reset (rst=0 at a clock edge): state IDLE, out_mantisa=0, out_exp=0, out_sign=0, ready=0, iteration counter=0.
- Reset wins over start and aborts any CALC in progress; no result is produced.
- Start accepted at edge N. Iterations occur at edges N+1..N+53. Outputs and ready=1 are registered at edge N+54.
- ready rises exactly once per accepted start. Outputs stay stable while ready=1.
- Next accepted start (edge M): ready=0 from edge M; outputs hold their old values until the new result is written.
- Outputs never change mid-calculation.

## Test plan
- Reset, then 1.0 double: in_mantisa=1<<52, in_exp=1023, flags=100, type=1, start high 2 cycles.
  - Expect ready rises 54 cycles after acceptance; out_mantisa=1<<52, out_exp=1023, sign 0.
  - The second start cycle must not restart the operation.
- 2.0: in_exp=1024, in_mantisa=1<<52 → out_mantisa=53'h16A09E667F3BCC, out_exp=1023.
- 4.0: in_exp=1025 → out_mantisa=1<<52, out_exp=1024. Small exponent in_exp=5 → out_exp=514.
- Specials:
  - flags=010, sign=1 → mantissa 0, exp 0, sign 1.
  - flags=001 → exp 0x7FF, mantissa 0.
  - Normal with sign=1 → exp 0x7FF, mantissa 53'h18000000000000.
- Single: type=0, in_mantisa=1<<52, in_exp=129 (4.0) → out_exp=128, out_mantisa=1<<52, low 29 bits 0.
- 32 random normals (random 52-bit fraction, exp 0..10, back-to-back starts):
  - Compare against a reference integer sqrt.
  - Assert rst=0 at iteration 20 of one operation → ready stays 0, outputs 0. The next start completes normally.
